beam_scan_controller: RTL and testbench



---
 rtl/supermic_pkg.sv | 17 +
 rtl/beam_adder_tree.sv | 47 ++++
 rtl/beam_scan_controller.sv | 216 +++++++++++++++++++++
 tb/tb_beam_scan_controller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/supermic_pkg.sv
// Shared definitions for the 16-microphone beam steering path.
package supermic_pkg;

  localparam int NUM_MICS = 16;
  localparam int PCM_W    = 19;
  localparam int DIR_W    = 5;
  localparam int SUM_W    = 23;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_ACCUM   = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } scan_state_e;

endpackage

// File: rtl/beam_adder_tree.sv
// Delay-and-sum beam former: registered sum of the 16 delayed channels.
module beam_adder_tree
  import supermic_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pcm_valid,
  input  logic [NUM_MICS*PCM_W-1:0] pcm_data,
  output logic [SUM_W-1:0]          beam_sum,
  output logic                      beam_valid
);

  logic [SUM_W-1:0] sum_d, sum_q;
  logic             valid_d, valid_q;
  logic [PCM_W-1:0] ch_s;

  // Sign-extend each channel and add; 16 x 19-bit cannot overflow 23 bits.
  always_comb begin
    sum_d   = sum_q;
    valid_d = pcm_valid;
    ch_s    = {PCM_W{1'b0}};
    if (pcm_valid) begin
      sum_d = {SUM_W{1'b0}};
      for (int i = 0; i < NUM_MICS; i++) begin
        ch_s  = pcm_data[i*PCM_W +: PCM_W];
        sum_d = sum_d + {{(SUM_W-PCM_W){ch_s[PCM_W-1]}}, ch_s};
      end
    end else begin
      sum_d = sum_q;
    end
  end

  // Beam sample register and its one-cycle valid strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= {SUM_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      valid_q <= valid_d;
    end
  end

  assign beam_sum   = sum_q;
  assign beam_valid = valid_q;

endmodule

// File: rtl/beam_scan_controller.sv
// Sweeps all steering directions, measures beam energy per direction and
// locks the beam onto the most energetic one.
module beam_scan_controller
  import supermic_pkg::*;
#(
  parameter int NUM_DIRS       = 32,
  parameter int SETTLE_SAMPLES = 64,
  parameter int WINDOW_LOG2    = 10,
  parameter int ENERGY_W       = 56
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pcm_valid,
  input  logic [NUM_MICS*PCM_W-1:0] delayed_pcm_data,
  input  logic                      start,
  input  logic                      continuous,
  output logic [DIR_W-1:0]          delay_select,
  output logic [SUM_W-1:0]          beam_sum,
  output logic                      beam_valid,
  output logic                      busy,
  output logic [DIR_W-1:0]          best_dir,
  output logic [ENERGY_W-1:0]       best_energy,
  output logic                      scan_done
);

  localparam int WINDOW  = 1 << WINDOW_LOG2;
  localparam int CNT_MAX = (WINDOW > SETTLE_SAMPLES) ? WINDOW : SETTLE_SAMPLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int SQ_W    = 2 * SUM_W;
  localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_SAMPLES - 1);
  localparam logic [CNT_W-1:0]    WINDOW_LAST = CNT_W'(WINDOW - 1);
  localparam logic [DIR_W-1:0]    DIR_LAST    = DIR_W'(NUM_DIRS - 1);
  localparam logic [ENERGY_W-1:0] ENERGY_MAX  = {ENERGY_W{1'b1}};

  scan_state_e         state_d, state_q;
  logic [DIR_W-1:0]    dir_d, dir_q;
  logic [CNT_W-1:0]    cnt_d, cnt_q;
  logic [ENERGY_W-1:0] acc_d, acc_q;
  logic [ENERGY_W-1:0] cand_energy_d, cand_energy_q;
  logic [DIR_W-1:0]    cand_dir_d, cand_dir_q;
  logic [ENERGY_W-1:0] best_energy_d, best_energy_q;
  logic [DIR_W-1:0]    best_dir_d, best_dir_q;
  logic [DIR_W-1:0]    delay_select_d, delay_select_q;
  logic                busy_d, busy_q;
  logic                scan_done_d, scan_done_q;

  logic [SUM_W-1:0]    tree_sum_s;
  logic                tree_valid_s;
  logic [SUM_W-1:0]    mag_s;
  logic [SQ_W-1:0]     sq_s;
  logic [ENERGY_W:0]   acc_sum_s;
  logic [ENERGY_W-1:0] acc_sat_s;
  logic                cand_win_s;
  logic [ENERGY_W-1:0] win_energy_s;
  logic [DIR_W-1:0]    win_dir_s;
  logic                restart_s;

  beam_adder_tree u_tree (
    .clk        (clk),
    .rst        (rst),
    .pcm_valid  (pcm_valid),
    .pcm_data   (delayed_pcm_data),
    .beam_sum   (tree_sum_s),
    .beam_valid (tree_valid_s)
  );

  // Square the beam via its magnitude and add to the window accumulator, saturating.
  always_comb begin
    mag_s     = tree_sum_s[SUM_W-1] ? ((~tree_sum_s) + {{(SUM_W-1){1'b0}}, 1'b1}) : tree_sum_s;
    sq_s      = {{SUM_W{1'b0}}, mag_s} * {{SUM_W{1'b0}}, mag_s};
    acc_sum_s = {1'b0, acc_q} + {{(ENERGY_W+1-SQ_W){1'b0}}, sq_s};
    acc_sat_s = acc_sum_s[ENERGY_W] ? ENERGY_MAX : acc_sum_s[ENERGY_W-1:0];
  end

  // Candidate selection: first direction always wins, later ones only if strictly larger.
  always_comb begin
    cand_win_s = (dir_q == {DIR_W{1'b0}}) || (acc_q > cand_energy_q);
    if (cand_win_s) begin
      win_energy_s = acc_q;
      win_dir_s    = dir_q;
    end else begin
      win_energy_s = cand_energy_q;
      win_dir_s    = cand_dir_q;
    end
  end

  // Scan sequencing: next state, counters and result registers.
  always_comb begin
    state_d        = state_q;
    dir_d          = dir_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    cand_energy_d  = cand_energy_q;
    cand_dir_d     = cand_dir_q;
    best_energy_d  = best_energy_q;
    best_dir_d     = best_dir_q;
    delay_select_d = delay_select_q;
    busy_d         = busy_q;
    scan_done_d    = 1'b0;
    restart_s      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          restart_s = 1'b1;
        end else begin
          delay_select_d = best_dir_q;
        end
      end
      ST_SETTLE: begin
        if (tree_valid_s) begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = {CNT_W{1'b0}};
            acc_d   = {ENERGY_W{1'b0}};
            state_d = ST_ACCUM;
          end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_ACCUM: begin
        if (tree_valid_s) begin
          acc_d = acc_sat_s;
          if (cnt_q == WINDOW_LAST) begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_COMPARE;
          end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          acc_d = acc_q;
        end
      end
      ST_COMPARE: begin
        cand_energy_d = win_energy_s;
        cand_dir_d    = win_dir_s;
        if (dir_q == DIR_LAST) begin
          best_energy_d = win_energy_s;
          best_dir_d    = win_dir_s;
          scan_done_d   = 1'b1;
          state_d       = ST_DONE;
        end else begin
          dir_d          = dir_q + {{(DIR_W-1){1'b0}}, 1'b1};
          delay_select_d = dir_q + {{(DIR_W-1){1'b0}}, 1'b1};
          cnt_d          = {CNT_W{1'b0}};
          state_d        = ST_SETTLE;
        end
      end
      ST_DONE: begin
        if (continuous || start) begin
          restart_s = 1'b1;
        end else begin
          busy_d         = 1'b0;
          delay_select_d = best_dir_q;
          state_d        = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (restart_s) begin
      dir_d          = {DIR_W{1'b0}};
      delay_select_d = {DIR_W{1'b0}};
      acc_d          = {ENERGY_W{1'b0}};
      cnt_d          = {CNT_W{1'b0}};
      cand_energy_d  = {ENERGY_W{1'b0}};
      cand_dir_d     = {DIR_W{1'b0}};
      busy_d         = 1'b1;
      state_d        = ST_SETTLE;
    end else begin
      busy_d = busy_d;
    end
  end

  // Controller state registers; reset aborts any scan and clears the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      dir_q          <= {DIR_W{1'b0}};
      cnt_q          <= {CNT_W{1'b0}};
      acc_q          <= {ENERGY_W{1'b0}};
      cand_energy_q  <= {ENERGY_W{1'b0}};
      cand_dir_q     <= {DIR_W{1'b0}};
      best_energy_q  <= {ENERGY_W{1'b0}};
      best_dir_q     <= {DIR_W{1'b0}};
      delay_select_q <= {DIR_W{1'b0}};
      busy_q         <= 1'b0;
      scan_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      dir_q          <= dir_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      cand_energy_q  <= cand_energy_d;
      cand_dir_q     <= cand_dir_d;
      best_energy_q  <= best_energy_d;
      best_dir_q     <= best_dir_d;
      delay_select_q <= delay_select_d;
      busy_q         <= busy_d;
      scan_done_q    <= scan_done_d;
    end
  end

  assign delay_select = delay_select_q;
  assign beam_sum     = tree_sum_s;
  assign beam_valid   = tree_valid_s;
  assign busy         = busy_q;
  assign best_dir     = best_dir_q;
  assign best_energy  = best_energy_q;
  assign scan_done    = scan_done_q;

endmodule

// File: tb/tb_beam_scan_controller.sv
// Self-checking bench: a small delay-module stand-in feeds per-direction sample
// tables, and expected results come from direct energy arithmetic on those tables.
module tb_beam_scan_controller;

  localparam int ND   = 4;
  localparam int S    = 2;
  localparam int WL   = 2;
  localparam int W    = 1 << WL;
  localparam int EW   = 56;
  localparam int KMAX = S + W;

  logic          clk = 1'b0;
  logic          rst, pcm_valid, start, continuous;
  logic [303:0]  pcm_data;
  logic [4:0]    delay_select, best_dir;
  logic [22:0]   beam_sum;
  logic          beam_valid, busy, scan_done;
  logic [EW-1:0] best_energy;

  int n_checks = 0;
  int n_errors = 0;

  logic signed [18:0] tab [ND][KMAX][16];

  always #5 clk = ~clk;

  beam_scan_controller #(
    .NUM_DIRS(ND), .SETTLE_SAMPLES(S), .WINDOW_LOG2(WL), .ENERGY_W(EW)
  ) dut (
    .clk(clk), .rst(rst), .pcm_valid(pcm_valid), .delayed_pcm_data(pcm_data),
    .start(start), .continuous(continuous), .delay_select(delay_select),
    .beam_sum(beam_sum), .beam_valid(beam_valid), .busy(busy),
    .best_dir(best_dir), .best_energy(best_energy), .scan_done(scan_done)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Sample tables: 0 single-hot on dir 2, 1 tie between dirs 1 and 3, 2 full-range random, 3 small random
  task automatic fill_tab(input int mode);
    logic [31:0] r;
    logic signed [18:0] v;
    for (int d = 0; d < ND; d++)
      for (int k = 0; k < KMAX; k++)
        for (int c = 0; c < 16; c++) begin
          r = $urandom();
          case (mode)
            0: v = (d == 2) ? 19'sd100 : 19'sd0;
            1: v = 19'sd0;
            2: v = r[18:0];
            default: v = (r[31:30] == 2'd0) ? 19'sd0 : (19'(r[9:0]) - 19'sd512);
          endcase
          tab[d][k][c] = v;
        end
    if (mode == 1) begin
      for (int k = 0; k < KMAX; k++)
        for (int c = 0; c < 16; c++) begin
          r = $urandom_range(0, 2000);
          v = 19'(r) - 19'sd1000;
          tab[1][k][c] = v;
          tab[3][k][c] = v;
        end
    end
  endtask

  function automatic longint dir_energy(input int d);
    longint e = 0;
    longint s;
    for (int k = S; k < S + W; k++) begin
      s = 0;
      for (int c = 0; c < 16; c++) s += longint'(tab[d][k][c]);
      e += s * s;
    end
    return e;
  endfunction

  task automatic set_data(input int ds, input int k);
    for (int c = 0; c < 16; c++)
      pcm_data[19*c +: 19] = (ds < ND && k < KMAX) ? tab[ds][k][c] : 19'd0;
  endtask

  task automatic run_scan(input int p, input bit cont, input int nscans,
                          input bit extra_start, input bit do_abort);
    int phase = 0, k_cur = 0, last_ds = 0, done_cnt = 0, bv = 0;
    bit k_reset = 1, started = 0, extra_done = 0, abort_next = 0, rst_issued = 0;
    bit post_done = 0, last_done = 0, finished = 0;
    int ds;
    int exp_best = 0;
    longint e [ND];
    for (int d = 0; d < ND; d++) e[d] = dir_energy(d);
    for (int d = 1; d < ND; d++) if (e[d] > e[exp_best]) exp_best = d;
    continuous = cont;
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      @(negedge clk);
      if (rst_issued) begin
        check_val("abort_busy", busy, 0);
        check_val("abort_delay_select", delay_select, 0);
        check_val("abort_best_dir", best_dir, 0);
        check_val("abort_best_energy", best_energy, 0);
        check_val("abort_beam_valid", beam_valid, 0);
        check_val("abort_beam_sum", beam_sum, 0);
        check_val("abort_scan_done", scan_done, 0);
        rst = 1'b0;
        finished = 1;
      end else begin
        if (post_done) begin
          post_done = 0;
          check_val("scan_done_pulse_width", scan_done, 0);
          if (last_done) begin
            check_val("idle_busy", busy, 0);
            check_val("locked_delay_select", delay_select, exp_best);
            finished = 1;
          end else begin
            check_val("restart_busy", busy, 1);
            check_val("restart_delay_select", delay_select, 0);
          end
        end
        if (started && beam_valid) bv++;
        if (scan_done) begin
          check_val("valid_samples_per_scan", bv, ND * KMAX);
          check_val("best_dir", best_dir, exp_best);
          check_val("best_energy", best_energy, e[exp_best]);
          check_val("busy_at_done", busy, 1);
          bv = 0;
          done_cnt++;
          post_done = 1;
          if (done_cnt >= nscans) begin
            continuous = 1'b0;
            last_done = 1;
          end
        end
        pcm_valid = 1'b0;
        start = 1'b0;
        if (abort_next) begin
          rst = 1'b1;
          rst_issued = 1;
          abort_next = 0;
        end else if (!finished) begin
          if (phase == 0) begin
            ds = int'(delay_select);
            if (k_reset || ds != last_ds) k_cur = 0;
            else k_cur++;
            k_reset = 0;
            last_ds = ds;
            set_data(ds, k_cur);
            pcm_valid = 1'b1;
            if (do_abort && started && ds == 2 && k_cur == 3) abort_next = 1;
          end else if (phase == 1 && !started) begin
            start = 1'b1;
            started = 1;
            k_reset = 1;
          end else if (extra_start && !extra_done && started && delay_select == 5'd1 && phase == 2) begin
            start = 1'b1;
            extra_done = 1;
          end
        end
        phase = (phase + 1) % p;
      end
    end
    if (!finished) check_val("scan_timeout", 0, 1);
    pcm_valid = 1'b0;
    start = 1'b0;
    continuous = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic beam_check(input string tag, input bit use_const, input logic [18:0] cval);
    int sum = 0;
    logic [31:0] r;
    logic [18:0] v;
    logic [22:0] exp_sum;
    @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      r = $urandom();
      v = use_const ? cval : r[18:0];
      pcm_data[19*c +: 19] = v;
      sum += int'($signed(v));
    end
    pcm_valid = 1'b1;
    exp_sum = sum[22:0];
    @(negedge clk);
    pcm_valid = 1'b0;
    check_val({tag, "_valid"}, beam_valid, 1);
    check_val({tag, "_sum"}, beam_sum, exp_sum);
    @(negedge clk);
    check_val({tag, "_valid_drop"}, beam_valid, 0);
  endtask

  initial begin
    rst = 1'b1; pcm_valid = 1'b0; start = 1'b0; continuous = 1'b0; pcm_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_val("reset_delay_select", delay_select, 0);
    check_val("reset_busy", busy, 0);
    check_val("reset_beam_valid", beam_valid, 0);
    check_val("reset_beam_sum", beam_sum, 0);
    check_val("reset_best_dir", best_dir, 0);
    check_val("reset_best_energy", best_energy, 0);
    check_val("reset_scan_done", scan_done, 0);

    beam_check("beam_all_minus1", 1'b1, 19'h7FFFF);
    beam_check("beam_all_max", 1'b1, 19'h3FFFF);
    for (int i = 0; i < 3; i++) beam_check("beam_random", 1'b0, 19'h0);

    fill_tab(0);
    run_scan(4, 1'b0, 1, 1'b0, 1'b0);
    fill_tab(1);
    run_scan(5, 1'b0, 1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      fill_tab(2 + (i % 2));
      run_scan(4 + int'($urandom_range(0, 2)), 1'b0, 1, (i == 1), 1'b0);
    end
    fill_tab(3);
    run_scan(4, 1'b1, 3, 1'b0, 1'b0);
    fill_tab(2);
    run_scan(6, 1'b0, 1, 1'b0, 1'b1);
    fill_tab(0);
    run_scan(4, 1'b0, 1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
